spell_mem_ctrl: RTL and testbench
=================================

# spell_mem_ctrl

Memory controller that services the load/store requests the spell execute stage produces. Code accesses (`!` store, `?` load) go to an on-chip code RAM, which also drives the instruction-fetch port. Data accesses (`w` store, `r` load) go out on a strobe/acknowledge bus with a timeout. It sits between the core sequencer and the code RAM and external data bus, and returns load data as the execute stage's `memory_input`.

## Interface
- `CODE_DEPTH`, 32: code RAM entries; power of two, at most 256.
- `TIMEOUT`, 15: maximum cycles waiting for `ext_ack` before aborting; at least 1.

- `clock`  in  1: single clock, rising edge.
- `reset`  in  1: synchronous, active-high.
- `req_valid`  in  1: request present.
- `req_ready`  out  1: controller can accept; a request is accepted when `req_valid & req_ready`.
- `req_write`  in  1: 1 = store, 0 = load.
- `req_type`  in  2: `MemoryTypeNone` / `MemoryTypeData` / `MemoryTypeCode`.
- `req_addr`  in  8: address.
- `req_wdata`  in  8: store data.
- `rsp_valid`  out  1: one-cycle completion pulse.
- `rsp_rdata`  out  8: load data, valid with `rsp_valid`; 0 for stores.
- `rsp_error`  out  1: valid with `rsp_valid`; 1 = external timeout.
- `fetch_addr`  in  8: instruction-fetch address (pc).
- `fetch_data`  out  8: combinational read of code RAM.
- `ext_stb`  out  1: external data bus request.
- `ext_we`  out  1: external write.
- `ext_addr`  out  8: external address.
- `ext_wdata`  out  8: external write data.
- `ext_rdata`  in  8: external read data, sampled on `ext_ack`.
- `ext_ack`  in  1: external completion.

## Operation
- FSM states: IDLE, CODE, EXT, RESP.
- `req_ready` is 1 only in IDLE.
- IDLE accepts a request and latches type, write, address and data.
  - Code type goes to CODE.
  - Data type goes to EXT.
  - None type goes to RESP with rdata 0 and error 0.
- CODE:
  - Store writes `code[addr mod CODE_DEPTH]`.
  - Load captures `code[addr mod CODE_DEPTH]`.
  - Then goes to RESP.
- EXT:
  - `ext_stb` = 1, and `ext_we`, `ext_addr`, `ext_wdata` are held stable.
  - On `ext_ack`, captures `ext_rdata` (loads only) and goes to RESP with error 0.
  - A wait counter starts at 0 on entry and increments each EXT cycle without ack.
  - If `ext_ack` is still absent when the counter reaches `TIMEOUT-1`, goes to RESP with error 1 and rdata 0.
  - `ext_ack` outside EXT is ignored.
- RESP: `rsp_valid` = 1 for exactly one cycle, then IDLE.
- Address wrap: only `addr[log2(CODE_DEPTH)-1:0]` indexes the code RAM, on both the request and fetch ports.
- `fetch_data` = `code[fetch_addr mod CODE_DEPTH]`, combinational. A code store becomes visible on the fetch port in the cycle after the CODE cycle. A same-cycle fetch of that address returns the old value.

## Timing
- Reset values:
  - State IDLE.
  - `req_ready` = 1.
  - `rsp_valid`, `rsp_error`, `ext_stb`, `ext_we` = 0.
  - `rsp_rdata`, `ext_addr`, `ext_wdata` = 0.
  - All code RAM entries = 8'hff (stop opcode).
- Reset mid-operation:
  - Any transaction is abandoned with no `rsp_valid`.
  - `ext_stb` is 0 in the cycle after reset is sampled.
  - A partially waited timeout is discarded.
- Latency, with acceptance at edge N:
  - Code access: `rsp_valid` at cycle N+2.
  - None type: `rsp_valid` at cycle N+1.
  - External access: `ext_stb` rises at N+1. If `ext_ack` is sampled at edge M, `rsp_valid` is in cycle M+1.
  - Timeout: `rsp_valid` at cycle N+1+TIMEOUT.
- `ext_ack` in the first EXT cycle is legal and completes in one bus cycle.
- Throughput: one request per 2 cycles minimum (None type); code accesses take 3 cycles per request.
- A new request may be accepted in the cycle after `rsp_valid`.

## Structure
- Shared package/include holds:
  - `MemoryTypeNone` = 2'd0, `MemoryTypeData` = 2'd1, `MemoryTypeCode` = 2'd2. These are the same constants used by the execute stage.
  - The FSM state encoding.
- One sub-module, `spell_code_ram`:
  - `CODE_DEPTH`×8 register array.
  - One synchronous write port and two combinational read ports.
  - Synchronous reset to 8'hff.
- The controller FSM, timeout counter and bus registers stay in `spell_mem_ctrl`.

## Test plan
- After reset, fetch every address 0..CODE_DEPTH-1 -> `fetch_data` = 8'hff; `req_ready` = 1; `ext_stb` = 0.
- Code store, addr 8'h05, data 8'h2b, accepted at edge N:
  - At cycle N+1, `fetch_data` for 5 is still 8'hff; from N+2 it reads 8'h2b.
  - `rsp_valid` at N+2 with rdata 0.
  - A later code load of addr 8'h25 (wraps to 5 at depth 32) returns 8'h2b.
- Data load, addr 8'h40, with `ext_ack` delayed 3 cycles and `ext_rdata` = 8'h99:
  - `ext_stb` high for exactly 4 cycles with `ext_we` = 0 and `ext_addr` = 8'h40.
  - Then `rsp_valid` with rdata 8'h99 and error 0.
- Data store, addr 8'h10, data 8'h77, no ack:
  - `ext_stb` high for TIMEOUT cycles.
  - Then `rsp_valid` with `rsp_error` = 1 and rdata 0; `req_ready` back to 1 the next cycle.
- Reset asserted in the 2nd EXT cycle -> `ext_stb` = 0 next cycle, no `rsp_valid`, state IDLE. A subsequent code store then works normally.
- Back-to-back None-type requests with `req_valid` held high -> accepted every 2nd cycle; each `rsp_valid` pulse is 1 cycle with rdata 0.

Source files
------------

// File: rtl/spell_mem_ctrl_pkg.sv
// Shared constants for the spell memory controller: memory access types
// (common with the execute stage), FSM state encoding and the latched request.
package spell_mem_ctrl_pkg;

  localparam logic [1:0] MemoryTypeNone = 2'd0;
  localparam logic [1:0] MemoryTypeData = 2'd1;
  localparam logic [1:0] MemoryTypeCode = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CODE = 2'd1,
    ST_EXT  = 2'd2,
    ST_RESP = 2'd3
  } mem_state_t;

  typedef struct packed {
    logic       write;
    logic [7:0] addr;
    logic [7:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/spell_code_ram.sv
// Code RAM: register array, one synchronous write port, two combinational
// read ports (request side and instruction fetch). Resets to the stop opcode.
module spell_code_ram #(
  parameter int DEPTH = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr_a,
  output logic [7:0]    rdata_a,
  input  logic [AW-1:0] raddr_b,
  output logic [7:0]    rdata_b
);

  logic [DEPTH-1:0][7:0] mem;

  always_ff @(posedge clock) begin
    if (reset) mem <= {DEPTH{8'hff}};
    else if (we) mem[waddr] <= wdata;
  end

  assign rdata_a = mem[raddr_a];
  assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/spell_mem_ctrl.sv
// Load/store controller for the spell core: code accesses hit the on-chip
// code RAM, data accesses go out on a strobe/ack bus guarded by a timeout.
module spell_mem_ctrl
  import spell_mem_ctrl_pkg::*;
#(
  parameter int CODE_DEPTH = 32,
  parameter int TIMEOUT    = 15
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_write,
  input  logic [1:0] req_type,
  input  logic [7:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       rsp_error,
  input  logic [7:0] fetch_addr,
  output logic [7:0] fetch_data,
  output logic       ext_stb,
  output logic       ext_we,
  output logic [7:0] ext_addr,
  output logic [7:0] ext_wdata,
  input  logic [7:0] ext_rdata,
  input  logic       ext_ack
);

  localparam int AW = $clog2(CODE_DEPTH);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  mem_state_t      state, next;
  mem_req_t        lat;
  logic [7:0]      rdata_q;
  logic            error_q;
  logic [CW-1:0]   wait_cnt;
  logic [7:0]      code_rdata;
  logic            code_we;

  always_ff @(posedge clock) begin
    if (reset) state <= ST_IDLE;
    else       state <= next;
  end

  always_comb begin
    next = state;
    case (state)
      ST_IDLE: if (req_valid) begin
        case (req_type)
          MemoryTypeCode: next = ST_CODE;
          MemoryTypeData: next = ST_EXT;
          default:        next = ST_RESP;
        endcase
      end
      ST_CODE: next = ST_RESP;
      ST_EXT:  if (ext_ack || wait_cnt == CNT_LAST) next = ST_RESP;
      ST_RESP: next = ST_IDLE;
      default: next = ST_IDLE;
    endcase
  end

  // rdata/error are cleared on acceptance so stores and None requests respond with 0
  always_ff @(posedge clock) begin
    if (reset) begin
      lat      <= '0;
      rdata_q  <= '0;
      error_q  <= 1'b0;
      wait_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: if (req_valid) begin
          lat      <= '{write: req_write, addr: req_addr, wdata: req_wdata};
          rdata_q  <= '0;
          error_q  <= 1'b0;
          wait_cnt <= '0;
        end
        ST_CODE: if (!lat.write) rdata_q <= code_rdata;
        ST_EXT: begin
          if (ext_ack) begin
            if (!lat.write) rdata_q <= ext_rdata;
          end else if (wait_cnt == CNT_LAST) begin
            error_q <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign code_we = (state == ST_CODE) && lat.write;

  spell_code_ram #(.DEPTH(CODE_DEPTH), .AW(AW)) u_code_ram (
    .clock   (clock),
    .reset   (reset),
    .we      (code_we),
    .waddr   (lat.addr[AW-1:0]),
    .wdata   (lat.wdata),
    .raddr_a (lat.addr[AW-1:0]),
    .rdata_a (code_rdata),
    .raddr_b (fetch_addr[AW-1:0]),
    .rdata_b (fetch_data)
  );

  // Upper fetch address bits do not index the code RAM.
  if (AW < 8) begin : g_fetch_hi
    logic fetch_hi_unused;
    assign fetch_hi_unused = ^fetch_addr[7:AW];
  end

  assign req_ready = (state == ST_IDLE);
  assign rsp_valid = (state == ST_RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_error = error_q;
  assign ext_stb   = (state == ST_EXT);
  assign ext_we    = (state == ST_EXT) && lat.write;
  assign ext_addr  = lat.addr;
  assign ext_wdata = lat.wdata;

endmodule

// File: tb/tb_spell_mem_ctrl.sv
// Directed bench for spell_mem_ctrl: reset state, code RAM store/load/wrap,
// external load with delayed ack, external timeout, mid-transfer reset, back-to-back.
module tb_spell_mem_ctrl;

  localparam int CODE_DEPTH = 32;
  localparam int TIMEOUT    = 15;

  logic       clock = 1'b0;
  logic       reset;
  logic       req_valid, req_ready, req_write;
  logic [1:0] req_type;
  logic [7:0] req_addr, req_wdata;
  logic       rsp_valid, rsp_error;
  logic [7:0] rsp_rdata;
  logic [7:0] fetch_addr, fetch_data;
  logic       ext_stb, ext_we, ext_ack;
  logic [7:0] ext_addr, ext_wdata, ext_rdata;

  int total = 0;
  int bad   = 0;

  spell_mem_ctrl #(.CODE_DEPTH(CODE_DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_type(req_type), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
    .fetch_addr(fetch_addr), .fetch_data(fetch_data),
    .ext_stb(ext_stb), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .ext_rdata(ext_rdata), .ext_ack(ext_ack)
  );

  always #5 clock = ~clock;

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  task automatic issue(input logic wr, input logic [1:0] t, input logic [7:0] a, input logic [7:0] d);
    req_valid = 1'b1; req_write = wr; req_type = t; req_addr = a; req_wdata = d;
  endtask

  task automatic test_reset;
    int errs = 0;
    for (int i = 0; i < CODE_DEPTH; i++) begin
      fetch_addr = 8'(i);
      step;
      total++;
      if (fetch_data !== 8'hff) begin
        bad++; errs++;
        $display("FAIL reset_fetch[%0d]: got %h want ff", i, fetch_data);
      end
    end
    total++;
    if ({req_ready, rsp_valid, rsp_error, ext_stb, ext_we} !== 5'b10000) begin
      bad++; $display("FAIL reset_ctrl: got rdy/rsp/err/stb/we=%b want 10000",
                      {req_ready, rsp_valid, rsp_error, ext_stb, ext_we});
    end
    total++;
    if ({rsp_rdata, ext_addr, ext_wdata} !== 24'h0) begin
      bad++; $display("FAIL reset_data: got rdata/addr/wdata=%h want 000000",
                      {rsp_rdata, ext_addr, ext_wdata});
    end
  endtask

  task automatic test_code_store;
    fetch_addr = 8'h05;
    issue(1'b1, 2'd2, 8'h05, 8'h2b);
    total++;
    if (req_ready !== 1'b1) begin bad++; $display("FAIL cs_ready: got %b want 1", req_ready); end
    step; // N+1: CODE cycle
    req_valid = 1'b0;
    total++;
    if (fetch_data !== 8'hff) begin bad++; $display("FAIL cs_fetch_old: got %h want ff", fetch_data); end
    total++;
    if (rsp_valid !== 1'b0) begin bad++; $display("FAIL cs_early_rsp: got %b want 0", rsp_valid); end
    step; // N+2: RESP
    total++;
    if (fetch_data !== 8'h2b) begin bad++; $display("FAIL cs_fetch_new: got %h want 2b", fetch_data); end
    total++;
    if ({rsp_valid, rsp_error, rsp_rdata} !== {1'b1, 1'b0, 8'h00}) begin
      bad++; $display("FAIL cs_rsp: got v/e/d=%b/%b/%h want 1/0/00", rsp_valid, rsp_error, rsp_rdata);
    end
    step;
    total++;
    if ({req_ready, rsp_valid} !== 2'b10) begin
      bad++; $display("FAIL cs_idle: got rdy/rsp=%b want 10", {req_ready, rsp_valid});
    end
  endtask

  task automatic test_code_load_wrap;
    fetch_addr = 8'h45;
    issue(1'b0, 2'd2, 8'h25, 8'h00);
    step;
    req_valid = 1'b0;
    total++;
    if (rsp_valid !== 1'b0) begin bad++; $display("FAIL cl_early_rsp: got %b want 0", rsp_valid); end
    step;
    total++;
    if ({rsp_valid, rsp_rdata} !== {1'b1, 8'h2b}) begin
      bad++; $display("FAIL cl_rsp: got v/d=%b/%h want 1/2b", rsp_valid, rsp_rdata);
    end
    total++;
    if (fetch_data !== 8'h2b) begin bad++; $display("FAIL cl_fetch_wrap: got %h want 2b", fetch_data); end
    step;
  endtask

  task automatic test_data_load;
    int stb_bad = 0;
    // stray ack while idle must not produce a response
    ext_ack = 1'b1; ext_rdata = 8'h55;
    step;
    ext_ack = 1'b0;
    total++;
    if ({req_ready, rsp_valid} !== 2'b10) begin
      bad++; $display("FAIL dl_stray_ack: got rdy/rsp=%b want 10", {req_ready, rsp_valid});
    end
    issue(1'b0, 2'd1, 8'h40, 8'h00);
    for (int i = 1; i <= 4; i++) begin
      step;
      req_valid = 1'b0;
      if (i == 4) begin ext_ack = 1'b1; ext_rdata = 8'h99; end
      if ({ext_stb, ext_we, ext_addr, rsp_valid} !== {1'b1, 1'b0, 8'h40, 1'b0}) stb_bad++;
    end
    total++;
    if (stb_bad != 0) begin bad++; $display("FAIL dl_bus: got %0d bad stb cycles want 0", stb_bad); end
    step;
    ext_ack = 1'b0; ext_rdata = 8'h00;
    total++;
    if (ext_stb !== 1'b0) begin bad++; $display("FAIL dl_stb_drop: got %b want 0", ext_stb); end
    total++;
    if ({rsp_valid, rsp_error, rsp_rdata} !== {1'b1, 1'b0, 8'h99}) begin
      bad++; $display("FAIL dl_rsp: got v/e/d=%b/%b/%h want 1/0/99", rsp_valid, rsp_error, rsp_rdata);
    end
    step;
  endtask

  task automatic test_data_store_timeout;
    int stb_cnt = 0;
    int bus_bad = 0;
    issue(1'b1, 2'd1, 8'h10, 8'h77);
    for (int i = 0; i < 40; i++) begin
      step;
      req_valid = 1'b0;
      if (!ext_stb) break;
      stb_cnt++;
      if ({ext_we, ext_addr, ext_wdata, rsp_valid} !== {1'b1, 8'h10, 8'h77, 1'b0}) bus_bad++;
    end
    total++;
    if (stb_cnt != TIMEOUT) begin bad++; $display("FAIL to_stb_len: got %0d want %0d", stb_cnt, TIMEOUT); end
    total++;
    if (bus_bad != 0) begin bad++; $display("FAIL to_bus: got %0d bad cycles want 0", bus_bad); end
    total++;
    if ({rsp_valid, rsp_error, rsp_rdata} !== {1'b1, 1'b1, 8'h00}) begin
      bad++; $display("FAIL to_rsp: got v/e/d=%b/%b/%h want 1/1/00", rsp_valid, rsp_error, rsp_rdata);
    end
    step;
    total++;
    if ({req_ready, rsp_valid} !== 2'b10) begin
      bad++; $display("FAIL to_ready: got rdy/rsp=%b want 10", {req_ready, rsp_valid});
    end
  endtask

  task automatic test_reset_mid_ext;
    int rsp_seen = 0;
    issue(1'b0, 2'd1, 8'h33, 8'h00);
    step; // EXT cycle 1
    req_valid = 1'b0;
    total++;
    if (ext_stb !== 1'b1) begin bad++; $display("FAIL rm_stb1: got %b want 1", ext_stb); end
    step; // EXT cycle 2
    reset = 1'b1;
    step;
    reset = 1'b0;
    total++;
    if ({ext_stb, rsp_valid, req_ready} !== 3'b001) begin
      bad++; $display("FAIL rm_after: got stb/rsp/rdy=%b want 001", {ext_stb, rsp_valid, req_ready});
    end
    for (int i = 0; i < 4; i++) begin
      step;
      if (rsp_valid || ext_stb) rsp_seen++;
    end
    total++;
    if (rsp_seen != 0) begin bad++; $display("FAIL rm_quiet: got %0d busy cycles want 0", rsp_seen); end
    fetch_addr = 8'h05;
    #0;
    total++;
    if (fetch_data !== 8'hff) begin bad++; $display("FAIL rm_ram_clear: got %h want ff", fetch_data); end
    fetch_addr = 8'h07;
    issue(1'b1, 2'd2, 8'h07, 8'h5a);
    step;
    req_valid = 1'b0;
    step;
    total++;
    if ({rsp_valid, rsp_rdata, fetch_data} !== {1'b1, 8'h00, 8'h5a}) begin
      bad++; $display("FAIL rm_code_store: got v/d/fetch=%b/%h/%h want 1/00/5a", rsp_valid, rsp_rdata, fetch_data);
    end
    step;
  endtask

  task automatic test_back_to_back;
    int pat_bad = 0;
    int accepts = 0;
    issue(1'b0, 2'd0, 8'h12, 8'h34);
    for (int i = 0; i < 8; i++) begin
      if (req_ready !== ((i % 2) == 0)) pat_bad++;
      if (rsp_valid !== ((i % 2) == 1)) pat_bad++;
      if (rsp_valid && rsp_rdata !== 8'h00) pat_bad++;
      if (req_ready && req_valid) accepts++;
      step;
    end
    req_valid = 1'b0;
    total++;
    if (pat_bad != 0) begin bad++; $display("FAIL b2b_pattern: got %0d bad samples want 0", pat_bad); end
    total++;
    if (accepts != 4) begin bad++; $display("FAIL b2b_accepts: got %0d want 4", accepts); end
    step;
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_type = 2'd0;
    req_addr = '0; req_wdata = '0; fetch_addr = '0; ext_rdata = '0; ext_ack = 1'b0;
    step; step;
    reset = 1'b0;
    test_reset;
    test_code_store;
    test_code_load_wrap;
    test_data_load;
    test_data_store_timeout;
    test_reset_mid_ext;
    test_back_to_back;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
